// File: rtl/sprite_compositor.sv
// Composites N_LAYERS priority-ordered sprites over a horizontally scrolling background
// for one requested pixel, reading sources from and writing the result to the display RAM.
module sprite_compositor #(
    parameter int X_MAX      = 160,
    parameter int Y_MAX      = 80,
    parameter int WIDTH      = 8,
    parameter int LEN        = 16384,
    parameter int N_LAYERS   = 2,
    parameter int SPR_W      = 16,
    parameter int SPR_H      = 16,
    parameter int SPR_BASE   = 15360,
    parameter int BG_BASE    = 12800,
    parameter int BG_W       = 128,
    parameter int BG_H       = 20,
    parameter int TRANSP_KEY = 0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                update,
    input  logic [$clog2(X_MAX)-1:0]            update_x,
    input  logic [$clog2(Y_MAX)-1:0]            update_y,
    output logic                                busy,
    output logic                                done,
    output logic [15:0]                         done_color,
    output logic                                frame_end,
    input  logic [N_LAYERS-1:0]                 layer_en,
    input  logic [N_LAYERS*$clog2(X_MAX)-1:0]   layer_x,
    input  logic [N_LAYERS*$clog2(Y_MAX)-1:0]   layer_y,
    input  logic [N_LAYERS-1:0]                 layer_frame,
    input  logic [$clog2(BG_W)-1:0]             scroll_x,
    output logic [$clog2(LEN)-1:0]              addr,
    output logic [WIDTH-1:0]                    din,
    input  logic [WIDTH-1:0]                    dout,
    output logic                                we,
    output logic                                collide,
    input  logic                                collide_clr
);
    localparam int AW       = $clog2(LEN);
    localparam int XW       = $clog2(X_MAX);
    localparam int YW       = $clog2(Y_MAX);
    localparam int XW1      = XW + 1;
    localparam int YW1      = YW + 1;
    localparam int BW       = $clog2(BG_W);
    localparam int SW       = $clog2(N_LAYERS + 1);
    localparam int FRAME_SZ = SPR_W * SPR_H;
    localparam int REP      = (WIDTH >= 16) ? 1 : 16 / WIDTH;

    localparam logic [SW-1:0]    BG_SLOT    = SW'(N_LAYERS);
    localparam logic [XW:0]      SPR_W_X    = XW1'(SPR_W);
    localparam logic [YW:0]      SPR_H_Y    = YW1'(SPR_H);
    localparam logic [YW:0]      BG_H_Y     = YW1'(BG_H);
    localparam logic [AW-1:0]    SPR_BASE_A = AW'(SPR_BASE);
    localparam logic [AW-1:0]    BG_BASE_A  = AW'(BG_BASE);
    localparam logic [AW-1:0]    BG_W_A     = AW'(BG_W);
    localparam logic [AW-1:0]    SPR_W_A    = AW'(SPR_W);
    localparam logic [AW-1:0]    X_MAX_A    = AW'(X_MAX);
    localparam logic [WIDTH-1:0] TRANSP_W   = WIDTH'(TRANSP_KEY);
    localparam logic [XW-1:0]    X_LAST     = XW'(X_MAX - 1);
    localparam logic [YW-1:0]    Y_LAST     = YW'(Y_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAP,
        S_WRITE
    } state_t;

    state_t state_q, state_d;

    logic [XW-1:0]          x_q;
    logic [YW-1:0]          y_q;
    logic [N_LAYERS*XW-1:0] lx_q;
    logic [N_LAYERS*YW-1:0] ly_q;
    logic [N_LAYERS-1:0]    len_q;
    logic [N_LAYERS-1:0]    lf_q;
    logic [BW-1:0]          scroll_q;
    logic [SW-1:0]          slot_q;
    logic [WIDTH-1:0]       pix_q;
    logic                   found_q;
    logic [1:0]             opq_q;
    logic [AW-1:0]          addr_q;

    logic [N_LAYERS-1:0]    spr_hit;
    logic [AW-1:0]          spr_addr [N_LAYERS];
    logic [BW-1:0]          bg_col;
    logic [AW-1:0]          bg_addr;
    logic [AW-1:0]          wr_addr;
    logic                   cur_hit;
    logic [AW-1:0]          cur_addr;
    logic                   cur_opaque;
    logic                   pair_opaque;
    logic [REP*WIDTH-1:0]   rep_pix;

    // Per-layer box test and sprite address; comparisons carry one spare bit so an
    // edge near the top of the coordinate range never wraps back onto the screen.
    for (genvar k = 0; k < N_LAYERS; k++) begin : g_layer
        logic [XW-1:0] sx;
        logic [YW-1:0] sy;
        assign sx = lx_q[k*XW +: XW];
        assign sy = ly_q[k*YW +: YW];
        assign spr_hit[k] = len_q[k]
                          && ({1'b0, y_q} >= {1'b0, sy}) && ({1'b0, y_q} < ({1'b0, sy} + SPR_H_Y))
                          && ({1'b0, x_q} >= {1'b0, sx}) && ({1'b0, x_q} < ({1'b0, sx} + SPR_W_X));
        assign spr_addr[k] = SPR_BASE_A + AW'((2 * k + int'(lf_q[k])) * FRAME_SZ)
                           + AW'(y_q - sy) * SPR_W_A + AW'(x_q - sx);
    end

    assign bg_col      = BW'(x_q) + scroll_q;
    assign bg_addr     = BG_BASE_A + AW'(y_q) * BG_W_A + AW'(bg_col);
    assign wr_addr     = AW'(y_q) * X_MAX_A + AW'(x_q);
    assign rep_pix     = {REP{pix_q}};
    assign pair_opaque = (N_LAYERS >= 2) && opq_q[0] && opq_q[1];

    always_comb begin
        cur_hit  = 1'b0;
        cur_addr = '0;
        if (slot_q == BG_SLOT) begin
            cur_hit  = ({1'b0, y_q} < BG_H_Y);
            cur_addr = bg_addr;
        end else begin
            for (int k = 0; k < N_LAYERS; k++) begin
                if (slot_q == SW'(k)) begin
                    cur_hit  = spr_hit[k];
                    cur_addr = spr_addr[k];
                end
            end
        end
    end

    // The background is opaque whenever it covers the row, whatever value it holds.
    assign cur_opaque = cur_hit && ((slot_q == BG_SLOT) || (dout != TRANSP_W));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (update) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  state_d = S_CAP;
            S_CAP:   state_d = (slot_q == BG_SLOT) ? S_WRITE : S_ISSUE;
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Slot reads present their address only on a hit; misses leave the last write address.
    always_comb begin
        addr = addr_q;
        if ((state_q == S_ISSUE || state_q == S_WAIT || state_q == S_CAP) && cur_hit) begin
            addr = cur_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q        <= '0;
            y_q        <= '0;
            lx_q       <= '0;
            ly_q       <= '0;
            len_q      <= '0;
            lf_q       <= '0;
            scroll_q   <= '0;
            slot_q     <= '0;
            pix_q      <= '0;
            found_q    <= 1'b0;
            opq_q      <= '0;
            addr_q     <= '0;
            din        <= '0;
            we         <= 1'b0;
            done       <= 1'b0;
            done_color <= '0;
            frame_end  <= 1'b0;
            busy       <= 1'b0;
            collide    <= 1'b0;
        end else begin
            we        <= 1'b0;
            done      <= 1'b0;
            frame_end <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (update) begin
                        x_q      <= update_x;
                        y_q      <= update_y;
                        lx_q     <= layer_x;
                        ly_q     <= layer_y;
                        len_q    <= layer_en;
                        lf_q     <= layer_frame;
                        scroll_q <= scroll_x;
                        slot_q   <= '0;
                        pix_q    <= '0;
                        found_q  <= 1'b0;
                        opq_q    <= '0;
                        busy     <= 1'b1;
                    end
                end
                S_CAP: begin
                    if (cur_opaque && !found_q) begin
                        pix_q   <= dout;
                        found_q <= 1'b1;
                    end
                    if (slot_q == SW'(0)) opq_q[0] <= cur_opaque;
                    if (slot_q == SW'(1)) opq_q[1] <= cur_opaque;
                    if (slot_q != BG_SLOT) slot_q <= slot_q + SW'(1);
                end
                S_WRITE: begin
                    addr_q     <= wr_addr;
                    din        <= pix_q;
                    we         <= 1'b1;
                    done       <= 1'b1;
                    done_color <= 16'(rep_pix);
                    frame_end  <= (x_q == X_LAST) && (y_q == Y_LAST);
                    busy       <= 1'b0;
                end
                default: ;
            endcase
            if (state_q == S_WRITE && pair_opaque) begin
                collide <= 1'b1;
            end else if (collide_clr) begin
                collide <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: directed scenes plus randomized pixels checked against a
// scene-level reference model reading the same RAM image.
module tb_sprite_compositor;
    localparam int X_MAX    = 160;
    localparam int Y_MAX    = 80;
    localparam int WIDTH    = 8;
    localparam int LEN      = 16384;
    localparam int NL       = 2;
    localparam int SPR_W    = 16;
    localparam int SPR_H    = 16;
    localparam int SPR_BASE = 15360;
    localparam int BG_BASE  = 12800;
    localparam int BG_W     = 128;
    localparam int BG_H     = 20;
    localparam int TKEY     = 0;
    localparam int XW       = 8;
    localparam int YW       = 7;
    localparam int BW       = 7;
    localparam int AW       = 14;
    localparam int LAT      = 3 * (NL + 1) + 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 update = 1'b0;
    logic [XW-1:0]        update_x = '0;
    logic [YW-1:0]        update_y = '0;
    logic                 busy, done, frame_end, we, collide;
    logic [15:0]          done_color;
    logic [NL-1:0]        layer_en = '0;
    logic [NL*XW-1:0]     layer_x = '0;
    logic [NL*YW-1:0]     layer_y = '0;
    logic [NL-1:0]        layer_frame = '0;
    logic [BW-1:0]        scroll_x = '0;
    logic [AW-1:0]        addr;
    logic [WIDTH-1:0]     din;
    logic [WIDTH-1:0]     dout;
    logic                 collide_clr = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sprite_compositor #(
        .X_MAX(X_MAX), .Y_MAX(Y_MAX), .WIDTH(WIDTH), .LEN(LEN), .N_LAYERS(NL),
        .SPR_W(SPR_W), .SPR_H(SPR_H), .SPR_BASE(SPR_BASE), .BG_BASE(BG_BASE),
        .BG_W(BG_W), .BG_H(BG_H), .TRANSP_KEY(TKEY)
    ) dut (
        .clk(clk), .rst(rst), .update(update), .update_x(update_x), .update_y(update_y),
        .busy(busy), .done(done), .done_color(done_color), .frame_end(frame_end),
        .layer_en(layer_en), .layer_x(layer_x), .layer_y(layer_y), .layer_frame(layer_frame),
        .scroll_x(scroll_x), .addr(addr), .din(din), .dout(dout), .we(we),
        .collide(collide), .collide_clr(collide_clr)
    );

    // RAM: source assets in mem (stimulus-owned), framebuffer in fb (DUT-written),
    // read data appears two cycles after the address.
    logic [7:0]    mem [0:LEN-1];
    logic [7:0]    fb  [0:BG_BASE-1];
    logic [7:0]    rd1;
    int            wr_cnt = 0;
    int            spr_cnt = 0;
    logic [AW-1:0] last_bg_addr = '0;

    always @(posedge clk) begin
        if (we) begin
            if (int'(addr) < BG_BASE) fb[addr] <= din;
            wr_cnt <= wr_cnt + 1;
        end
        rd1  <= (int'(addr) < BG_BASE) ? fb[addr] : mem[addr];
        dout <= rd1;
        if (busy && int'(addr) >= SPR_BASE) spr_cnt <= spr_cnt + 1;
        if (busy && int'(addr) >= BG_BASE && int'(addr) < SPR_BASE) last_bg_addr <= addr;
    end

    int   l_en [NL];
    int   l_x  [NL];
    int   l_y  [NL];
    int   l_fr [NL];
    int   sc;
    logic coll_m = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scene-level reference: walk layers in priority order, then the background.
    function automatic void model(input int x, input int y, output logic [7:0] pix, output logic both);
        bit found;
        bit opq [NL+1];
        int v;
        found = 0;
        pix = '0;
        v = 0;
        for (int s = 0; s <= NL; s++) begin
            opq[s] = 0;
            if (s < NL) begin
                if (l_en[s] != 0 && y >= l_y[s] && y < l_y[s] + SPR_H && x >= l_x[s] && x < l_x[s] + SPR_W) begin
                    v = int'(mem[SPR_BASE + (2 * s + l_fr[s]) * SPR_W * SPR_H + (y - l_y[s]) * SPR_W + (x - l_x[s])]);
                    opq[s] = (v != TKEY);
                end
            end else if (y < BG_H) begin
                v = int'(mem[BG_BASE + y * BG_W + (x + sc) % BG_W]);
                opq[s] = 1;
            end
            if (opq[s] && !found) begin
                pix = v[7:0];
                found = 1;
            end
        end
        both = opq[0] && opq[1];
    endfunction

    task automatic drive_scene();
        for (int k = 0; k < NL; k++) begin
            layer_en[k]             = (l_en[k] != 0);
            layer_x[k*XW +: XW]     = l_x[k][XW-1:0];
            layer_y[k*YW +: YW]     = l_y[k][YW-1:0];
            layer_frame[k]          = l_fr[k][0];
        end
        scroll_x = sc[BW-1:0];
    endtask

    task automatic run_pixel(input int x, input int y, input bit hold, input bit clr);
        logic [7:0] ep;
        logic       both, exp_coll;
        int         lat, wc0, ea;
        model(x, y, ep, both);
        exp_coll = (clr ? 1'b0 : coll_m) | both;
        ea = y * X_MAX + x;
        @(negedge clk);
        update_x = x[XW-1:0];
        update_y = y[YW-1:0];
        drive_scene();
        collide_clr = clr;
        update = 1'b1;
        wc0 = wr_cnt;
        @(negedge clk);
        if (!hold) update = 1'b0;
        chk("busy_after_accept", busy, 1);
        update_x    = XW'($urandom);
        update_y    = YW'($urandom);
        layer_x     = (NL*XW)'($urandom);
        layer_y     = (NL*YW)'($urandom);
        layer_en    = NL'($urandom);
        layer_frame = NL'($urandom);
        scroll_x    = BW'($urandom);
        lat = -1;
        for (int k = 1; k <= 4 * LAT; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) begin
            chk("done_timeout", done, 1);
        end else begin
            chk("latency", lat, LAT);
            chk("we_at_done", we, 1);
            chk("wr_addr", addr, ea);
            chk("din", din, ep);
            chk("done_color", done_color, {ep, ep});
            chk("frame_end", frame_end, (x == X_MAX - 1 && y == Y_MAX - 1));
            chk("busy_at_done", busy, 0);
            chk("collide", collide, exp_coll);
        end
        update = 1'b0;
        collide_clr = 1'b0;
        coll_m = exp_coll;
        @(negedge clk);
        @(negedge clk);
        chk("one_write", wr_cnt - wc0, 1);
        chk("we_low_after", we, 0);
        chk("done_low_after", done, 0);
        chk("fb_value", fb[ea], ep);
    endtask

    initial begin
        int wc0, s0;
        for (int i = 0; i < LEN; i++) mem[i] = ($urandom_range(0, 9) < 3) ? 8'h00 : 8'($urandom_range(1, 255));
        for (int k = 0; k < NL; k++) begin
            l_en[k] = 0; l_x[k] = 0; l_y[k] = 0; l_fr[k] = 0;
        end
        sc = 0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we", we, 0);
        chk("rst_addr", addr, 0);
        chk("rst_din", din, 0);
        chk("rst_done_color", done_color, 0);
        chk("rst_frame_end", frame_end, 0);
        chk("rst_collide", collide, 0);
        rst = 1'b0;

        // background wrap
        for (int i = 0; i < BG_W; i++) mem[BG_BASE + 3 * BG_W + i] = 8'(i);
        sc = 120;
        run_pixel(20, 3, 0, 0);
        chk("bg_read_addr", last_bg_addr, BG_BASE + 3 * BG_W + 12);
        chk("bg_wrap_value", fb[3 * X_MAX + 20], 12);

        // priority and transparency
        for (int k = 0; k < NL; k++) begin
            l_en[k] = 1; l_x[k] = 5; l_y[k] = 20; l_fr[k] = 0;
        end
        mem[SPR_BASE] = 8'h00;
        mem[SPR_BASE + 2 * SPR_W * SPR_H] = 8'h55;
        run_pixel(5, 20, 0, 0);
        chk("prio_transp_value", fb[20 * X_MAX + 5], 8'h55);
        chk("prio_no_collide", collide, 0);
        mem[SPR_BASE] = 8'hAA;
        run_pixel(5, 20, 0, 0);
        chk("prio_top_value", fb[20 * X_MAX + 5], 8'hAA);
        chk("prio_collide", collide, 1);

        // reset during the wait cycle of slot 0
        @(negedge clk);
        update_x = 8'd30; update_y = 7'd4; drive_scene(); update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_we", we, 0);
        chk("midrst_addr", addr, 0);
        chk("midrst_din", din, 0);
        chk("midrst_done_color", done_color, 0);
        chk("midrst_frame_end", frame_end, 0);
        chk("midrst_collide", collide, 0);
        coll_m = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wc0 = wr_cnt;
        repeat (3 * LAT) @(negedge clk);
        chk("midrst_no_write", wr_cnt - wc0, 0);
        run_pixel(30, 4, 0, 0);

        // clear racing a collision, then clear with no collision
        mem[SPR_BASE] = 8'hAA;
        run_pixel(5, 20, 0, 1);
        chk("race_set_wins", collide, 1);
        mem[SPR_BASE] = 8'h00;
        run_pixel(5, 20, 0, 1);
        chk("race_cleared", collide, 0);

        // frame end with a sprite hit, update held high throughout
        l_en[0] = 1; l_x[0] = 150; l_y[0] = 70; l_fr[0] = 1;
        l_en[1] = 0;
        s0 = spr_cnt;
        run_pixel(159, 79, 1, 0);
        chk("edge_sprite_read", (spr_cnt - s0) > 0, 1);

        // misses: row outside the box, and a box whose right edge would wrap past 255
        l_y[0] = 0;
        s0 = spr_cnt;
        run_pixel(159, 79, 0, 0);
        chk("miss_no_sprite_read", spr_cnt - s0, 0);
        l_x[0] = 250; l_y[0] = 0;
        s0 = spr_cnt;
        run_pixel(5, 5, 0, 0);
        chk("nowrap_no_sprite_read", spr_cnt - s0, 0);

        // randomized scenes
        for (int t = 0; t < 40; t++) begin
            int x, y;
            x = $urandom_range(0, X_MAX - 1);
            y = ($urandom_range(0, 1) == 1) ? $urandom_range(0, BG_H + 5) : $urandom_range(0, Y_MAX - 1);
            for (int k = 0; k < NL; k++) begin
                l_en[k] = ($urandom_range(0, 3) != 0) ? 1 : 0;
                l_x[k]  = (x + 256 - $urandom_range(0, SPR_W + 4)) % 256;
                l_y[k]  = (y + 128 - $urandom_range(0, SPR_H + 4)) % 128;
                l_fr[k] = $urandom_range(0, 1);
            end
            sc = $urandom_range(0, BG_W - 1);
            run_pixel(x, y, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
